// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - instruction word layout, opcodes and assembler helper for fetch_ctrl
package fetch_ctrl_pkg;

    localparam int INSTRUCTION_WIDTH = 6;
    localparam int OPCODE_WIDTH      = 3;
    localparam int REG_WIDTH         = 3;

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = 3'b000;
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = 3'b001;
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = 3'b010;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = 3'b011;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = 3'b100;
    localparam logic [OPCODE_WIDTH-1:0] OP_AND   = 3'b101;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = 3'b110;
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = 3'b111;

    function automatic logic [INSTRUCTION_WIDTH-1:0] asm(
        input logic [OPCODE_WIDTH-1:0] op,
        input logic [REG_WIDTH-1:0]    rd
    );
        return {op, rd};
    endfunction

    function automatic logic [OPCODE_WIDTH-1:0] opcode_of(
        input logic [INSTRUCTION_WIDTH-1:0] word
    );
        return word[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - program counter register with synchronous load and increment
module fetch_pc #(
    parameter int ADDR_WIDTH = 5,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] pc
);

    localparam logic [ADDR_WIDTH-1:0] RESET_VAL = ADDR_WIDTH'(RESET_PC);

    // Load wins over increment; increment wraps naturally at 2^ADDR_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VAL;
        end else if (load) begin
            pc <= load_addr;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer; optional HALT stop under FETCH_HALT_EN
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int RESET_PC   = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic [ADDR_WIDTH-1:0]        rom_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] rom_data,
    output logic [INSTRUCTION_WIDTH-1:0] instr,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    input  logic                         jump_en,
    input  logic [ADDR_WIDTH-1:0]        jump_addr,
    output logic [ADDR_WIDTH-1:0]        pc,
    output logic                         busy,
    output logic                         halted
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_PRESENT = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] RESET_VAL = ADDR_WIDTH'(RESET_PC);

    state_t                  state, state_next;
    logic                    pc_load, pc_inc, instr_load, handshake;
    logic [ADDR_WIDTH-1:0]   pc_load_addr;

    fetch_pc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (pc_load),
        .load_addr (pc_load_addr),
        .inc       (pc_inc),
        .pc        (pc)
    );

    assign rom_addr    = pc;
    assign instr_valid = (state == ST_PRESENT);
    assign busy        = (state == ST_FETCH) || (state == ST_PRESENT);
    assign handshake   = instr_valid && instr_ready;

`ifdef FETCH_HALT_EN
    assign halted = (state == ST_HALTED);
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= '0;
        end else if (instr_load) begin
            instr <= rom_data;
        end
    end

    always_comb begin
        state_next   = state;
        pc_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_load_addr = jump_addr;
        instr_load   = 1'b0;
        case (state)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_next   = ST_FETCH;
                    pc_load      = 1'b1;
                    pc_load_addr = RESET_VAL;
                end
            end
            ST_FETCH: begin
                instr_load = 1'b1;
                state_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (handshake) begin
`ifdef FETCH_HALT_EN
                    // A HALT word freezes the PC at its own address and ignores any jump.
                    if (opcode_of(instr) == OP_HALT) begin
                        state_next = ST_HALTED;
                    end else
`endif
                    begin
                        state_next = ST_FETCH;
                        if (jump_en) begin
                            pc_load = 1'b1;
                        end else begin
                            pc_inc = 1'b1;
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         start;
    logic [4:0]                   rom_addr;
    logic [INSTRUCTION_WIDTH-1:0] rom_data;
    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic                         instr_valid;
    logic                         instr_ready;
    logic                         jump_en;
    logic [4:0]                   jump_addr;
    logic [4:0]                   pc;
    logic                         busy;
    logic                         halted;

    logic [INSTRUCTION_WIDTH-1:0] mem [32];
    int errors = 0;
    int checks = 0;

    assign rom_data = mem[rom_addr];

    always #5 clk = ~clk;

    fetch_ctrl #(.ADDR_WIDTH(5), .RESET_PC(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},       32'(pc), 32'd0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check({tag, "_instr"},    32'(instr), 32'd0);
        check({tag, "_valid"},    32'(instr_valid), 32'd0);
        check({tag, "_busy"},     32'(busy), 32'd0);
        check({tag, "_halted"},   32'(halted), 32'd0);
    endtask

    // In PRESENT at exp_pc: verify, then accept with ready=1 and pass the FETCH cycle.
    task automatic accept(input string tag, input int exp_pc);
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_pc"},    32'(pc), 32'(exp_pc));
        check({tag, "_instr"}, 32'(instr), 32'(mem[exp_pc]));
        instr_ready = 1'b1;
        step();
        check({tag, "_fetch_valid"}, 32'(instr_valid), 32'd0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 6'(i + 8);
        rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; jump_addr = '0;
        step();
        step();
        check_reset_values("reset");
        rst_n = 1'b1;
        step();
        check_reset_values("idle");

        // start at N: FETCH in N+1, valid in N+2
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_fetch_valid", 32'(instr_valid), 32'd0);
        check("start_pc", 32'(pc), 32'd0);
        step();

        // streaming with wrap 31 -> 0
        for (int i = 0; i < 35; i++) accept("stream", i % 32);

        // now PRESENT at pc=3: jump without handshake is ignored
        instr_ready = 1'b0; jump_en = 1'b1; jump_addr = 5'd20;
        step();
        check("nohs_jump_pc", 32'(pc), 32'd3);
        check("nohs_jump_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        step();
        check("jump_pc", 32'(pc), 32'd20);
        jump_en = 1'b0;
        step();
        check("jump_instr", 32'(instr), 32'(mem[20]));

        // jump back to 7, then stall 5 cycles there
        jump_en = 1'b1; jump_addr = 5'd7;
        step();
        jump_en = 1'b0; instr_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_pc", 32'(pc), 32'd7);
            check("stall_instr", 32'(instr), 32'(mem[7]));
            step();
        end
        instr_ready = 1'b1;
        step();
        check("release_pc", 32'(pc), 32'd8);
        instr_ready = 1'b0;
        step();
        check("release_instr", 32'(instr), 32'(mem[8]));

        // jump to the current pc refetches the same word
        jump_en = 1'b1; jump_addr = 5'd8; instr_ready = 1'b1;
        step();
        check("self_jump_pc", 32'(pc), 32'd8);
        jump_en = 1'b0; instr_ready = 1'b0;
        step();
        check("self_jump_instr", 32'(instr), 32'(mem[8]));

        // start while busy (PRESENT then FETCH) has no effect
        start = 1'b1;
        step();
        check("busy_start_present_pc", 32'(pc), 32'd8);
        check("busy_start_present_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        step();
        check("busy_start_fetch_pc", 32'(pc), 32'd9);
        step();
        start = 1'b0;
        check("busy_start_next_pc", 32'(pc), 32'd9);
        check("busy_start_next_instr", 32'(instr), 32'(mem[9]));
        for (int i = 9; i < 12; i++) accept("to12", i);

        // asynchronous reset mid-PRESENT at pc=12
        check("pre_reset_pc", 32'(pc), 32'd12);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        step();
        rst_n = 1'b1;
        instr_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_pc", 32'(pc), 32'd0);
        step();
        check("restart_instr", 32'(instr), 32'(mem[0]));

        // HALT word at address 5
        mem[5] = asm(OP_HALT, 3'd0);
        for (int i = 0; i < 5; i++) accept("to_halt", i);
        check("halt_word_instr", 32'(instr), 32'(mem[5]));
        instr_ready = 1'b1;
        step();
`ifdef FETCH_HALT_EN
        instr_ready = 1'b0;
        check("halted_flag", 32'(halted), 32'd1);
        check("halted_pc", 32'(pc), 32'd5);
        check("halted_busy", 32'(busy), 32'd0);
        step();
        check("halted_hold", 32'(halted), 32'd1);
        check("halted_hold_pc", 32'(pc), 32'd5);
        start = 1'b1;
        step();
        start = 1'b0;
        check("unhalt_flag", 32'(halted), 32'd0);
        check("unhalt_pc", 32'(pc), 32'd0);
        step();
        check("unhalt_instr", 32'(instr), 32'(mem[0]));
`else
        instr_ready = 1'b0;
        check("no_halt_flag", 32'(halted), 32'd0);
        check("no_halt_pc", 32'(pc), 32'd6);
        step();
        check("no_halt_instr", 32'(instr), 32'(mem[6]));
        check("no_halt_valid", 32'(instr_valid), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
